// File: rtl/keypad_scan_4x4_if.sv
// Keypad scanner pin bundle: matrix side (rows in, columns out) plus the key-event outputs.
// master = scanner, slave = board/consumer side.
interface keypad_scan_4x4_if;
    logic [3:0] row_in;
    logic [3:0] col_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_sel,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_sel,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: one active-low column per slot, whole-scan debounce,
// one key_valid pulse per accepted press, key_held until the release is confirmed.
module keypad_scan_4x4 #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic            sys_clk,
    input logic            reset,
    keypad_scan_4x4_if.master bus
);
    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DB_N     = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

    logic [3:0]       r_row_meta, r_row_sync;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [1:0]       r_acc_n;     // pressed count so far this scan, saturates at 2
    logic [3:0]       r_acc_code;
    state_e           r_state, w_state_d;
    logic [3:0]       r_cand, w_cand_d;
    logic [3:0]       r_cnt, w_cnt_d;
    logic [3:0]       r_key_code, w_key_code_d;
    logic             r_key_valid, w_key_valid_d;
    logic             r_key_held;

    logic       w_slot_end, w_scan_end;
    logic [2:0] w_col_n;
    logic [1:0] w_row_idx;
    logic [3:0] w_sum;
    logic [1:0] w_tot;
    logic [3:0] w_code_new;
    logic       w_res_key, w_res_none;
    logic [3:0] w_cnt_inc;

    assign w_slot_end = (r_div == DIV_LAST);
    assign w_scan_end = w_slot_end && (r_col == 2'd3);

    always_comb begin
        w_col_n   = '0;
        w_row_idx = '0;
        for (int r = 3; r >= 0; r--) begin
            if (!r_row_sync[r]) begin
                w_col_n   = w_col_n + 3'd1;
                w_row_idx = 2'(r);
            end
        end
    end

    assign w_sum      = {2'b00, r_acc_n} + {1'b0, w_col_n};
    assign w_tot      = (w_sum >= 4'd2) ? 2'd2 : w_sum[1:0];
    // code = 4*row + col; only meaningful when the scan total is exactly one
    assign w_code_new = ((r_acc_n == 2'd0) && (w_col_n == 3'd1)) ? {w_row_idx, r_col} : r_acc_code;
    assign w_res_key  = (w_tot == 2'd1);
    assign w_res_none = (w_tot == 2'd0);
    assign w_cnt_inc  = r_cnt + 4'd1;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
            r_div      <= '0;
            r_col      <= '0;
            r_acc_n    <= '0;
            r_acc_code <= '0;
        end else begin
            r_row_meta <= bus.row_in;
            r_row_sync <= r_row_meta;
            r_div      <= w_slot_end ? '0 : r_div + 1'b1;
            if (w_slot_end) begin
                r_col <= r_col + 2'd1;
                if (r_col == 2'd3) begin
                    r_acc_n    <= '0;
                    r_acc_code <= '0;
                end else begin
                    r_acc_n    <= w_tot;
                    r_acc_code <= w_code_new;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cand      <= w_cand_d;
            r_cnt       <= w_cnt_d;
            r_key_code  <= w_key_code_d;
            r_key_valid <= w_key_valid_d;
            r_key_held  <= (w_state_d == StHeld) || (w_state_d == StRelDb);
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cand_d      = r_cand;
        w_cnt_d       = r_cnt;
        w_key_code_d  = r_key_code;
        w_key_valid_d = 1'b0;
        if (w_scan_end) begin
            unique case (r_state)
                StIdle: begin
                    if (w_res_key) begin
                        w_state_d = StPressDb;
                        w_cand_d  = w_code_new;
                        w_cnt_d   = 4'd1;
                    end
                end
                StPressDb: begin
                    if (w_res_key && (w_code_new == r_cand)) begin
                        w_cnt_d = w_cnt_inc;
                        if (w_cnt_inc == DB_N) begin
                            w_state_d     = StHeld;
                            w_key_code_d  = r_cand;
                            w_key_valid_d = 1'b1;
                        end
                    end else if (w_res_key) begin
                        w_cand_d = w_code_new;
                        w_cnt_d  = 4'd1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (!(w_res_key && (w_code_new == r_key_code))) begin
                        w_state_d = StRelDb;
                        w_cnt_d   = w_res_none ? 4'd1 : 4'd0;
                    end
                end
                StRelDb: begin
                    if (w_res_none) begin
                        w_cnt_d = w_cnt_inc;
                        if (w_cnt_inc == DB_N) w_state_d = StIdle;
                    end else if (w_res_key && (w_code_new == r_key_code)) begin
                        w_state_d = StHeld;
                    end else begin
                        w_cnt_d = 4'd0;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    assign bus.col_sel   = ~(4'b0001 << r_col);
    assign bus.key_code  = r_key_code;
    assign bus.key_valid = r_key_valid;
    assign bus.key_held  = r_key_held;
endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with a behavioural 4x4 switch-matrix model.
module tb_keypad_scan_4x4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DB       = 2;
    localparam int          SCAN     = 16;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;
    int held_low_cnt = 0;
    logic [3:0] last_code = '0;

    keypad_scan_4x4_if kp ();

    keypad_scan_4x4 #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (kp)
    );

    always #5 sys_clk = ~sys_clk;

    // A pressed switch pulls its row low while its column is driven low.
    always_comb begin
        kp.row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !kp.col_sel[c]) kp.row_in[r] = 1'b0;
    end

    always @(negedge sys_clk) begin
        if (kp.key_valid) begin
            pulse_cnt = pulse_cnt + 1;
            last_code = kp.key_code;
        end
        if (!kp.key_held) held_low_cnt = held_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    int         base, hbase;
    logic       any_out;
    logic [3:0] exp_col;

    initial begin
        cycles(3);
        reset = 1'b0;
        // Column walk: cycle n after release drives column (n/4)%4.
        any_out = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (n < 32) begin
                exp_col = ~(4'b0001 << ((n / 4) % 4));
                check("col_walk", kp.col_sel, exp_col);
            end
            if (kp.key_valid || kp.key_held || (kp.key_code != 4'd0)) any_out = 1'b1;
            cycles(1);
        end
        check("idle_outputs", any_out, 1'b0);

        // Steady press of code 9 (row 2, col 1).
        base = pulse_cnt;
        pressed = 16'h0200;
        cycles(20);
        check("press9_early", pulse_cnt - base, 0);
        cycles(3 * SCAN + 3 - 20);
        check("press9_pulse", pulse_cnt - base, 1);
        check("press9_code", last_code, 4'd9);
        check("press9_held", kp.key_held, 1'b1);
        hbase = held_low_cnt;
        cycles(10 * SCAN);
        check("press9_norepeat", pulse_cnt - base, 1);
        check("press9_heldall", held_low_cnt - hbase, 0);
        pressed = '0;
        cycles(5 * SCAN);
        check("rel9_held", kp.key_held, 1'b0);

        // Bouncy press: one scan on, one scan off.
        base = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            pressed = 16'h0200;
            cycles(SCAN);
            pressed = '0;
            cycles(SCAN);
        end
        cycles(2 * SCAN);
        check("bounce_nopulse", pulse_cnt - base, 0);
        check("bounce_held", kp.key_held, 1'b0);

        // Codes 0 and 5 together are MULTI; dropping 0 leaves a clean 5.
        base = pulse_cnt;
        pressed = 16'h0021;
        cycles(5 * SCAN);
        check("multi_nopulse", pulse_cnt - base, 0);
        pressed = 16'h0020;
        cycles(3 * SCAN + 3);
        check("multi_then5", pulse_cnt - base, 1);
        check("multi_code5", last_code, 4'd5);
        pressed = '0;
        cycles(5 * SCAN);

        // HELD on 9, release two scans, re-press: held drops, second pulse.
        base = pulse_cnt;
        pressed = 16'h0200;
        cycles(4 * SCAN);
        check("rp_first", pulse_cnt - base, 1);
        hbase = held_low_cnt;
        pressed = '0;
        cycles(2 * SCAN);
        pressed = 16'h0200;
        cycles(4 * SCAN);
        check("rp_helddrop", (held_low_cnt - hbase) > 0, 1'b1);
        check("rp_second", pulse_cnt - base, 2);
        check("rp_code", last_code, 4'd9);

        // Release only one scan: still held, no new pulse.
        hbase = held_low_cnt;
        pressed = '0;
        cycles(SCAN);
        pressed = 16'h0200;
        cycles(4 * SCAN);
        check("short_rel_held", held_low_cnt - hbase, 0);
        check("short_rel_nopulse", pulse_cnt - base, 2);
        pressed = '0;
        cycles(5 * SCAN);

        // Reset while HELD on code 3.
        base = pulse_cnt;
        pressed = 16'h0008;
        cycles(4 * SCAN);
        check("k3_pulse", pulse_cnt - base, 1);
        check("k3_code", kp.key_code, 4'd3);
        reset = 1'b1;
        cycles(1);
        check("rst_held", kp.key_held, 1'b0);
        check("rst_code", kp.key_code, 4'd0);
        check("rst_col", kp.col_sel, 4'b1110);
        check("rst_valid", kp.key_valid, 1'b0);
        reset = 1'b0;
        base = pulse_cnt;
        cycles(30);
        check("rst_nopulse", pulse_cnt - base, 0);
        cycles(30);
        check("rst_repulse", pulse_cnt - base, 1);
        check("rst_recode", last_code, 4'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan_4x4.md
# keypad_scan_4x4

Matrix-keypad scanner for a 4x4 button matrix. It is the input-side counterpart of the multiplexed 7-segment driver: it drives one active-low column at a time, reads the rows, and debounces over whole scans. It emits one pulse per accepted keypress plus a 4-bit key code. The block sits beside the display driver in the board top level and feeds game or control logic with clean key events.

## Interface
Parameters:
- SCAN_DIV, 50000 — sys_clk cycles per column slot (1 ms at 50 MHz); legal range >= 4.
- DEBOUNCE_SCANS, 4 — consecutive identical full-scan results needed to accept a press or a release; legal range 2..15.

Ports:
- sys_clk  input  1  — single system clock; all logic on rising edge.
- reset  input  1  — synchronous, active-high reset.
- row_in  input  4  — matrix rows, active-low, with external pull-ups; asynchronous to sys_clk.
- col_sel  output  4  — column drive, active-low one-hot.
- key_code  output  4  — last accepted key, equal to 4*row + col.
- key_valid  output  1  — one-cycle pulse when a press is accepted.
- key_held  output  1  — high from acceptance until the release is confirmed.

## Operation
- row_in passes through a 2-flop synchronizer before any use.
- Divider counter div runs 0..SCAN_DIV-1. At div = SCAN_DIV-1 (the slot's last cycle) the synchronized rows are sampled for the current column. On the next cycle col advances 0→1→2→3→0 and col_sel = ~(1<<col).
- Scan accumulation:
  - Across the 4 slots, count pressed switches (row bit = 0) and record the row/col of any pressed switch.
  - Scan result after column 3's sample: NONE if count = 0; KEY(code) if count = 1; MULTI if count >= 2.
  - MULTI is treated as "not a valid key" everywhere.
- FSM, evaluated only on the end-of-scan cycle, with candidate register cand and debounce counter cnt (4 bits):
  - IDLE: KEY(k) → PRESS_DB, cand = k, cnt = 1. NONE/MULTI → stay.
  - PRESS_DB:
    - KEY(cand) → cnt+1; if the new cnt = DEBOUNCE_SCANS → HELD, key_code = cand, key_valid pulse.
    - KEY(other) → cand = other, cnt = 1.
    - NONE/MULTI → IDLE.
  - HELD: KEY(key_code) → stay. Anything else → REL_DB, cnt = 1 if NONE, cnt = 0 otherwise.
  - REL_DB:
    - NONE → cnt+1; at DEBOUNCE_SCANS → IDLE.
    - KEY(key_code) → HELD.
    - Other KEY or MULTI → cnt = 0, stay. The matrix must be fully released before a new key can be accepted.
- key_held = 1 in HELD and REL_DB. key_code holds its value until the next acceptance.

## Timing
- Reset values:
  - col_sel = 4'b1110, div = 0, col = 0, state IDLE, cnt = 0, cand = 0.
  - key_code = 0, key_valid = 0, key_held = 0.
  - Synchronizer flops reset to 4'b1111.
- One full scan = 4*SCAN_DIV cycles. The end-of-scan cycle is div = SCAN_DIV-1 with col = 3.
- key_valid is registered: it asserts the cycle after the end-of-scan cycle that completes debounce, lasts exactly 1 cycle, and key_code is valid in that same cycle.
- key_held rises together with key_valid. It falls on the cycle after the end-of-scan that completes the release debounce.
- Press latency from a stable press: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scans, plus 3 cycles (synchronizer plus output register).
- Reset mid-operation (any state): all registers return to their reset values on the next edge. No key_valid is emitted on or after that edge until a fresh full debounce completes.
- No held-key auto-repeat: at most one key_valid per press.
- Counter wrap: div and col wrap without gaps. cnt never exceeds DEBOUNCE_SCANS.

## Test plan
Bench parameters: SCAN_DIV = 4, DEBOUNCE_SCANS = 2 (one scan = 16 cycles).

- Reset, no keys → col_sel steps 1110, 1101, 1011, 0111, each for 4 cycles, and repeats. key_valid, key_held and key_code stay 0 for 200 cycles.
- Hold row 2 / col 1 (row_in[2] low while col_sel[1] = 0) steadily → exactly one key_valid with key_code = 9 within 2–3 scans. key_held = 1 for the whole hold; no further pulses over 10 scans.
- Press code 9 for one scan, release one scan, press one scan, repeat → zero key_valid pulses.
- Press codes 0 and 5 together for 5 scans → no pulse (MULTI). Then release code 0 only → one pulse with key_code = 5.
- From HELD on code 9:
  - Release for 2 scans, then re-press → key_held drops, then a second key_valid with code 9.
  - Release for only 1 scan, then re-press → key_held stays 1 and no second pulse.
- Assert reset for 1 cycle while in HELD with code 3 → next cycle key_held = 0, key_code = 0, col_sel = 1110. With the key still pressed, key_valid returns only after 2 or more full scans.
